// File: rtl/datapath_pkg.sv
// Shared definitions for the pipelined datapath: instruction field positions,
// ALU operation codes and decode helpers.
// Ports: none (package).
package datapath_pkg;

    // Instruction word field positions
    localparam int unsigned LOAD_BIT = 31;
    localparam int unsigned IMM_BIT  = 30;
    localparam int unsigned OP_HI    = 29;
    localparam int unsigned OP_LO    = 26;
    localparam int unsigned RS_HI    = 25;
    localparam int unsigned RS_LO    = 21;
    localparam int unsigned RT_HI    = 20;
    localparam int unsigned RT_LO    = 16;
    localparam int unsigned RD_HI    = 15;
    localparam int unsigned RD_LO    = 11;

    // ALU operation codes; every code above OP_SRA passes operand B through
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;

    // Immediate and load forms write rt; register-register forms write rd
    function automatic logic [4:0] dest_sel(input logic [31:0] ir);
        return (ir[LOAD_BIT] | ir[IMM_BIT]) ? ir[RT_HI:RT_LO] : ir[RD_HI:RD_LO];
    endfunction

    // rt is a source operand only for register-register ALU forms
    function automatic logic uses_rt(input logic [31:0] ir);
        return ~ir[LOAD_BIT] & ~ir[IMM_BIT];
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU for the pipelined datapath.
// Ports:
//   op   in  4      operation code (datapath_pkg OP_*)
//   a    in  WIDTH  operand A
//   b    in  WIDTH  operand B (low $clog2(WIDTH) bits give the shift amount)
//   y    out WIDTH  result, carries discarded
//   zero out 1      y == 0
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] sh_s;

    assign sh_s = b[SH_W-1:0];

    // Operation select
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  y = a << sh_s;
            OP_SRL:  y = a >> sh_s;
            OP_SRA:  y = $unsigned($signed(a) >>> sh_s);
            default: y = b;
        endcase
    end

    assign zero = (y == {WIDTH{1'b0}});

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage pipelined datapath with internal register file and ALU.
// S1 holds the accepted instruction word; S2 holds decoded fields and operands;
// the output register holds the written-back result until consumed.
// Build option: define FORWARDING_EN to bypass the S2 result into operand
// capture; otherwise a RAW hazard inserts a one-cycle bubble.
// Ports:
//   clk          in  1      rising-edge clock
//   reset        in  1      asynchronous active-low reset
//   ir_in        in  32     instruction word
//   data_in      in  WIDTH  load data, captured with ir_in
//   ir_valid     in  1      instruction offered
//   ir_ready     out 1      instruction accepted when ir_valid & ir_ready
//   result       out WIDTH  written-back value
//   result_dest  out 5      destination register of result
//   result_zero  out 1      result == 0
//   result_valid out 1      unconsumed result present
//   result_ready in  1      consumer takes result
//   busy         out 1      any stage holds a valid entry
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 32,
    parameter int IMM_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ir_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ir_valid,
    output logic             ir_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       result_dest,
    output logic             result_zero,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    localparam logic [5:0] REG_LIM = 6'(REG_COUNT);

    logic             s1_valid_r;
    logic [31:0]      s1_ir_r;
    logic [WIDTH-1:0] s1_data_r;
    logic             s2_valid_r;
    logic             s2_load_r;
    logic [3:0]       s2_op_r;
    logic [4:0]       s2_dest_r;
    logic [WIDTH-1:0] s2_a_r;
    logic [WIDTH-1:0] s2_b_r;
    logic [WIDTH-1:0] s2_data_r;
    logic [WIDTH-1:0] res_r;
    logic [4:0]       res_dest_r;
    logic             res_zero_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] regs_r [1:REG_COUNT-1];

    logic             stall_s;
    logic             accept_s;
    logic             s1_adv_s;
    logic             hold_s;
    logic             s2_live_s;
    logic             s2_wr_s;
    logic             haz_rs_s;
    logic             haz_rt_s;
    logic [4:0]       s1_rs_s;
    logic [4:0]       s1_rt_s;
    logic [WIDTH-1:0] s1_imm_s;
    logic [WIDTH-1:0] rf_a_s;
    logic [WIDTH-1:0] rf_b_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] rt_val_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH-1:0] alu_y_s;
    logic             alu_zero_s;
    logic [WIDTH-1:0] s2_res_s;
    logic             s2_zero_s;

    datapath_alu #(.WIDTH(WIDTH)) u_alu (
        .op   (s2_op_r),
        .a    (s2_a_r),
        .b    (s2_b_r),
        .y    (alu_y_s),
        .zero (alu_zero_s)
    );

    assign s2_res_s  = s2_load_r ? s2_data_r : alu_y_s;
    assign s2_zero_s = s2_load_r ? (s2_data_r == {WIDTH{1'b0}}) : alu_zero_s;

    assign s1_rs_s  = s1_ir_r[RS_HI:RS_LO];
    assign s1_rt_s  = s1_ir_r[RT_HI:RT_LO];
    assign s1_imm_s = WIDTH'($signed(s1_ir_r[IMM_W-1:0]));

    // Only a destination that is actually stored can create a dependency;
    // register 0 and unimplemented addresses always read as zero anyway.
    assign s2_live_s = s2_valid_r & (s2_dest_r != 5'd0) & ({1'b0, s2_dest_r} < REG_LIM);
    assign haz_rs_s  = s1_valid_r & s2_live_s & (s1_rs_s == s2_dest_r);
    assign haz_rt_s  = s1_valid_r & s2_live_s & uses_rt(s1_ir_r) & (s1_rt_s == s2_dest_r);

    assign stall_s  = res_valid_r & ~result_ready;
    assign s2_wr_s  = s2_live_s & ~stall_s;
    assign s1_adv_s = s1_valid_r & ~stall_s & ~hold_s;
    assign ir_ready = reset & ~stall_s & (~s1_valid_r | s1_adv_s);
    assign accept_s = ir_valid & ir_ready;

`ifdef FORWARDING_EN
    assign hold_s   = 1'b0;
    assign op_a_s   = haz_rs_s ? s2_res_s : rf_a_s;
    assign rt_val_s = haz_rt_s ? s2_res_s : rf_b_s;
`else
    assign hold_s   = haz_rs_s | haz_rt_s;
    assign op_a_s   = rf_a_s;
    assign rt_val_s = rf_b_s;
`endif

    assign op_b_s = s1_ir_r[IMM_BIT] ? s1_imm_s : rt_val_s;

    // Register file read ports; unmatched addresses (0, >= REG_COUNT) give 0
    always_comb begin
        rf_a_s = {WIDTH{1'b0}};
        rf_b_s = {WIDTH{1'b0}};
        for (int i = 1; i < REG_COUNT; i++) begin
            rf_a_s = (s1_rs_s == 5'(i)) ? regs_r[i] : rf_a_s;
            rf_b_s = (s1_rt_s == 5'(i)) ? regs_r[i] : rf_b_s;
        end
    end

    // S1: instruction word capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s1_ir_r    <= 32'd0;
            s1_data_r  <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_ir_r    <= ir_in;
            s1_data_r  <= data_in;
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // S2: decoded fields and operands; a held S1 leaves a bubble behind
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_r <= 1'b0;
            s2_load_r  <= 1'b0;
            s2_op_r    <= 4'd0;
            s2_dest_r  <= 5'd0;
            s2_a_r     <= {WIDTH{1'b0}};
            s2_b_r     <= {WIDTH{1'b0}};
            s2_data_r  <= {WIDTH{1'b0}};
        end else if (!stall_s) begin
            s2_valid_r <= s1_adv_s;
            if (s1_adv_s) begin
                s2_load_r <= s1_ir_r[LOAD_BIT];
                s2_op_r   <= s1_ir_r[OP_HI:OP_LO];
                s2_dest_r <= dest_sel(s1_ir_r);
                s2_a_r    <= op_a_s;
                s2_b_r    <= op_b_s;
                s2_data_r <= s1_data_r;
            end
        end
    end

    // Output register: a new result may replace one being consumed this edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_r <= 1'b0;
            res_r       <= {WIDTH{1'b0}};
            res_dest_r  <= 5'd0;
            res_zero_r  <= 1'b0;
        end else if (!stall_s) begin
            res_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                res_r      <= s2_res_s;
                res_dest_r <= s2_dest_r;
                res_zero_r <= s2_zero_s;
            end
        end
    end

    // Register file writeback on the S2 -> output transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (s2_wr_s) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (s2_dest_r == 5'(i)) begin
                    regs_r[i] <= s2_res_s;
                end
            end
        end
    end

    assign result       = res_r;
    assign result_dest  = res_dest_r;
    assign result_zero  = res_zero_r;
    assign result_valid = res_valid_r;
    assign busy         = s1_valid_r | s2_valid_r | res_valid_r;

endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe (WIDTH=32, REG_COUNT=8).
// A program-order architectural model computes each instruction's result at
// acceptance; the output stream is compared in order against it.
module tb_datapath_pipe;

    localparam int W  = 32;
    localparam int RC = 8;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   ir_in;
    logic [W-1:0]  data_in;
    logic          ir_valid;
    logic          ir_ready;
    logic [W-1:0]  result;
    logic [4:0]    result_dest;
    logic          result_zero;
    logic          result_valid;
    logic          result_ready;
    logic          busy;

    always #5 clk = ~clk;

    datapath_pipe #(.WIDTH(W), .REG_COUNT(RC), .IMM_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .ir_in        (ir_in),
        .data_in      (data_in),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .result       (result),
        .result_dest  (result_dest),
        .result_zero  (result_zero),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    typedef struct packed {
        logic [W-1:0] val;
        logic [4:0]   dest;
        int           acc;
    } exp_t;

    int            n_chk = 0;
    int            n_bad = 0;
    logic [W-1:0]  m_regs [32];
    exp_t          exp_q [$];
    logic [31:0]   iss_q [$];
    logic [W-1:0]  iss_d [$];
    int            lat_q [$];
    int            cyc_n = 0;
    int            ready_lo = 0;
    logic          rdy = 1'b1;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_res = '0;
    logic [W-1:0]  last_val = '0;
    logic [4:0]    last_dest = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {1'b0, 1'b0, op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {1'b0, 1'b1, op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mk_ld(input logic [4:0] rt);
        return {1'b1, 1'b0, 4'd0, 5'd0, rt, 16'd0};
    endfunction

    // Architectural execution of one instruction in program order
    task automatic m_accept(input logic [31:0] ir, input logic [W-1:0] d);
        logic [W-1:0] a, b, y, sgn;
        logic [4:0]   dst;
        int           sh;
        exp_t         e;
        sgn = {1'b1, {(W-1){1'b0}}};
        a   = m_regs[ir[25:21]];
        b   = ir[30] ? {{(W-16){ir[15]}}, ir[15:0]} : m_regs[ir[20:16]];
        dst = (ir[31] | ir[30]) ? ir[20:16] : ir[15:11];
        sh  = int'(b % W);
        y   = '0;
        if (ir[31]) y = d;
        else begin
            case (ir[29:26])
                4'd0: y = a + b;
                4'd1: y = a - b;
                4'd2: y = a & b;
                4'd3: y = a | b;
                4'd4: y = a ^ b;
                4'd5: y[0] = ((a ^ sgn) < (b ^ sgn));
                4'd6: y = a << sh;
                4'd7: y = a >> sh;
                4'd8: y = (a >> sh) | (a[W-1] ? ~({W{1'b1}} >> sh) : {W{1'b0}});
                default: y = b;
            endcase
        end
        if (dst != 5'd0 && int'(dst) < RC) m_regs[dst] = y;
        e.val = y; e.dest = dst; e.acc = cyc_n;
        exp_q.push_back(e);
    endtask

    task automatic push(input logic [31:0] ir, input logic [W-1:0] d);
        iss_q.push_back(ir);
        iss_d.push_back(d);
    endtask

    // One clock: drive at negedge, sample 1ns before the next rising edge
    task automatic cyc();
        exp_t        e;
        logic        acc, cons;
        logic [31:0] ir;
        logic [W-1:0] d;
        @(negedge clk);
        result_ready = rdy;
        if (iss_q.size() > 0) begin
            ir_valid = 1'b1; ir_in = iss_q[0]; data_in = iss_d[0];
        end else begin
            ir_valid = 1'b0; ir_in = $urandom; data_in = $urandom;
        end
        #4;
        if (prev_stall) begin
            chk("hold_result", result, prev_res);
            chk("hold_valid", result_valid, 1'b1);
        end
        acc  = ir_valid & ir_ready;
        cons = result_valid & result_ready;
        if (!ir_ready) ready_lo++;
        if (cons) begin
            if (exp_q.size() == 0) chk("spurious_result", result_valid, 1'b0);
            else begin
                e = exp_q.pop_front();
                chk("result", result, e.val);
                chk("dest", result_dest, e.dest);
                chk("zero", result_zero, e.val == '0);
                lat_q.push_back(cyc_n - e.acc);
                last_val  = result;
                last_dest = result_dest;
            end
        end
        if (acc) begin
            ir = iss_q.pop_front();
            d  = iss_d.pop_front();
            m_accept(ir, d);
        end
        prev_stall = result_valid & ~result_ready;
        prev_res   = result;
        cyc_n++;
    endtask

    task automatic drain();
        int n;
        n   = 0;
        rdy = 1'b1;
        while ((iss_q.size() > 0 || exp_q.size() > 0) && n < 2000) begin
            cyc();
            n++;
        end
        chk("drain_left", exp_q.size() + iss_q.size(), 0);
        repeat (3) cyc();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0; ir_valid = 1'b0; result_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #4;
            chk("rst_ir_ready", ir_ready, 1'b0);
            chk("rst_result_valid", result_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_result", result, '0);
            @(negedge clk);
        end
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        exp_q.delete(); iss_q.delete(); iss_d.delete();
        prev_stall = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ir_valid = 1'b0; ir_in = '0; data_in = '0; result_ready = 1'b1;
        do_reset(3);

        // Reset mid-stream: accepted LOAD must never produce a result
        push(mk_ld(5'd1), 32'd5);
        cyc(); cyc();
        do_reset(2);
        ready_lo = 0;
        repeat (3) cyc();
        chk("ready_after_release", ready_lo, 0);
        push(mk_r(4'd0, 5'd1, 5'd0, 5'd6), '0);
        drain();
        chk("r1_after_reset", last_val, 32'd0);
        chk("r1_after_reset_dest", last_dest, 5'd6);

        // Dependent load / add-immediate pair
        lat_q.delete(); ready_lo = 0;
        push(mk_ld(5'd1), 32'd7);
        push(mk_i(4'd0, 5'd1, 5'd2, 16'hFFFD), '0);
        drain();
        chk("pair_count", lat_q.size(), 2);
        if (lat_q.size() == 2) begin
            chk("load_latency", lat_q[0], 3);
            chk("addi_latency", lat_q[1], FWD ? 3 : 4);
        end
        chk("hazard_ready_low", ready_lo, FWD ? 0 : 1);
        chk("addi_value", last_val, 32'd4);
        chk("addi_dest", last_dest, 5'd2);

        // Shifts and signed compare
        push(mk_ld(5'd3), 32'h8000_0000);
        push(mk_ld(5'd5), 32'd4);
        push(mk_r(4'd8, 5'd3, 5'd5, 5'd4), '0);
        drain();
        chk("sra", last_val, 32'hF800_0000);
        push(mk_r(4'd7, 5'd3, 5'd5, 5'd6), '0);
        drain();
        chk("srl", last_val, 32'h0800_0000);
        push(mk_r(4'd5, 5'd3, 5'd5, 5'd7), '0);
        drain();
        chk("slt", last_val, 32'd1);

        // Backpressure with three instructions queued
        rdy = 1'b0;
        push(mk_i(4'd0, 5'd0, 5'd1, 16'd11), '0);
        push(mk_i(4'd0, 5'd0, 5'd2, 16'd22), '0);
        push(mk_i(4'd0, 5'd0, 5'd3, 16'd33), '0);
        push(mk_r(4'd0, 5'd1, 5'd2, 5'd4), '0);
        repeat (3) cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_ir_ready", ir_ready, 1'b0);
            chk("bp_valid", result_valid, 1'b1);
            chk("bp_result", result, 32'd11);
        end
        drain();
        chk("bp_r4", last_val, 32'd33);
        push(mk_r(4'd0, 5'd1, 5'd3, 5'd5), '0);
        drain();
        chk("bp_readback", last_val, 32'd44);

        // Writes to R0 and to an unimplemented register
        push(mk_i(4'd0, 5'd0, 5'd0, 16'd9), '0);
        drain();
        chk("r0_write_val", last_val, 32'd9);
        chk("r0_write_dest", last_dest, 5'd0);
        push(mk_i(4'd0, 5'd0, 5'd31, 16'd12), '0);
        drain();
        chk("r31_write_val", last_val, 32'd12);
        chk("r31_write_dest", last_dest, 5'd31);
        push(mk_r(4'd3, 5'd0, 5'd31, 5'd2), '0);
        drain();
        chk("r0_r31_read", last_val, 32'd0);

        // Randomized stream with random backpressure
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3, 0) != 0) push($urandom, $urandom);
            rdy = ($urandom_range(3, 0) != 0);
            cyc();
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
- Parametrised two-stage pipelined successor to the single-cycle datapath.
- Accepts 32-bit instruction words through a valid/ready handshake and owns an internal register file and ALU.
- Writes each result back into the register file and presents it on a registered output with backpressure.
- Sits between the instruction sequencer and the top-level CPU; replaces the free-running IR/mux/regfile/ALU chain.

Parameters:
- WIDTH, 32, datapath and register width; legal values 8..64.
- REG_COUNT, 32, number of implemented registers; legal values 2..32. Addresses >= REG_COUNT read as 0 and writes to them are dropped.
- IMM_W, 16, immediate field width taken from ir_in[IMM_W-1:0]; it is sign-extended to WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ir_in  in  32  instruction word. Fields:
  - [31] LOAD
  - [30] IMM
  - [29:26] OP
  - [25:21] rs
  - [20:16] rt
  - [15:11] rd
- data_in  in  WIDTH  load data, sampled together with ir_in on acceptance.
- ir_valid  in  1  instruction offered.
- ir_ready  out  1  instruction accepted when ir_valid & ir_ready at a rising edge.
- result  out  WIDTH  written-back value.
- result_dest  out  5  destination register of result.
- result_zero  out  1  result == 0.
- result_valid  out  1  output register holds an unconsumed result.
- result_ready  in  1  consumer takes result when result_valid & result_ready.
- busy  out  1  any stage valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears all registers to 0, S1/S2 valid flags, result, result_dest, result_zero and result_valid.
  - ir_ready=0 while reset is asserted, then 1 from the first cycle after release.
  - Instructions in flight are discarded; no writeback occurs.
- Register 0 always reads as 0; writes to register 0 are dropped, but result and result_valid are still produced.
- Pipeline timing:
  - S1 latches ir_in/data_in on acceptance.
  - S2 latches the decoded fields, operand A=R[rs], and operand B=(IMM ? sext(imm) : R[rt]).
  - On S2 -> output transfer: ALU executes, the regfile is written, and result/result_dest/result_valid are updated.
- Latency: accepted at edge k -> result_valid=1 after edge k+2 (no stalls). Throughput is 1 instruction per cycle.
- Destination: rt if IMM or LOAD, otherwise rd.
- LOAD=1: result=data_in captured at acceptance; OP and operands are ignored.
- OP codes (results are WIDTH bits; carries discarded):
  - 0 ADD
  - 1 SUB (A-B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLT (signed, result 1/0)
  - 6 SLL
  - 7 SRL
  - 8 SRA
  - 9-15 PASS B
  - Shifts use B[$clog2(WIDTH)-1:0].
- Advance rule: stall = result_valid & ~result_ready.
  - On stall all stages hold, ir_ready=0, and no regfile write occurs.
  - Writeback happens exactly once per instruction, on the edge it enters the output register.
- Simultaneous output consume and new result on the same edge: the new result replaces the old one and result_valid stays 1.
- Regfile read/write collision on the same edge: the read in the S1->S2 transfer sees the new value (see hazard handling).
- RAW hazard: S1 source (rs, or rt when !IMM & !LOAD) equals S2 destination (nonzero) while both are valid. Handling depends on the macro below.

Optional Feature:
- FORWARDING_EN defined:
  - The S2 ALU result is bypassed into the S1->S2 operand capture.
  - Dependent back-to-back instructions run with no bubble.
- FORWARDING_EN undefined:
  - On a hazard, S1 holds one cycle, ir_ready=0, and a bubble (S2 invalid) is inserted.
  - The operand is then read from the regfile after writeback.
- Results are identical in both builds; only timing differs.

Decomposition:
- Shared package datapath_pkg holds:
  - OP code localparams
  - instruction field bit positions (LOAD_BIT=31, IMM_BIT=30, OP_HI/LO, RS/RT/RD ranges)
  - helper function for destination select
- One sub-module, datapath_alu (combinational, WIDTH-parametrised, OP/A/B -> Y, zero), instantiated once.
- Register file and pipeline control stay inline.

Test Plan:
- Reset mid-stream: accept LOAD R1=5, assert reset before result_valid -> no result produced; R1 reads 0 after release; ir_ready=0 during reset.
- Load R1=7 then ADD-IMM R2=R1+(-3) (imm=16'hFFFD) -> results 7 then 4, dest 1 then 2, back-to-back. With FORWARDING_EN: 1 result per cycle. Without: exactly one bubble, and ir_ready low for one cycle.
- Load R3=32'h8000_0000, SRA R4=R3>>B with R5=4 -> R4=32'hF800_0000. SRL -> 32'h0800_0000. SLT R3<R5 -> 1.
- Backpressure: result_ready=0 for 5 cycles with 3 instructions queued -> ir_ready=0, result held stable, each regfile write occurs exactly once; on release, results appear in order.
- Writes to R0 and to R31 with REG_COUNT=8 -> result_valid pulses with correct value; subsequent reads return 0.
- WIDTH=16 build: ADD 16'hFFFF+1 -> result 0, result_zero=1, carry discarded.
